// File: rtl/gpio_in_debounce.sv
// -----------------------------------------------------------------------------
// gpio_in_debounce
//
// Input conditioning for the AHB GPIO peripheral. Every pin bit is
// synchronised to HCLK, debounced against a shared sample tick, and turned
// into one-cycle rise/fall pulses. The pulses set sticky per-bit pending
// flags that are OR-ed into a single interrupt line.
//
// Parameters
//   WIDTH         number of pin bits
//   PRESCALE      HCLK cycles per sample tick (1..65535)
//   STABLE_COUNT  consecutive differing ticks needed to accept a level (1..15)
//
// Ports
//   HCLK         in   1      system clock
//   HRESETn      in   1      asynchronous active-low reset
//   PINS_IN      in   WIDTH  raw asynchronous pin levels
//   ENABLE       in   1      1 = debounce active, 0 = bypass (synchronised only)
//   IRQ_CLEAR    in   WIDTH  write-one-to-clear mask for pending flags
//   GPIOIN       out  WIDTH  debounced level, feeds the GPIO GPIOIN port
//   RISE         out  WIDTH  one-cycle pulse on an accepted 0->1 change
//   FALL         out  WIDTH  one-cycle pulse on an accepted 1->0 change
//   IRQ_PENDING  out  WIDTH  sticky event flags
//   IRQ          out  1      OR of IRQ_PENDING
// -----------------------------------------------------------------------------
module gpio_in_debounce #(
    parameter int WIDTH        = 16,
    parameter int PRESCALE     = 1000,
    parameter int STABLE_COUNT = 4
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic [WIDTH-1:0] PINS_IN,
    input  logic             ENABLE,
    input  logic [WIDTH-1:0] IRQ_CLEAR,
    output logic [WIDTH-1:0] GPIOIN,
    output logic [WIDTH-1:0] RISE,
    output logic [WIDTH-1:0] FALL,
    output logic [WIDTH-1:0] IRQ_PENDING,
    output logic             IRQ
);

    // Prescaler terminal count and per-bit counter limit. The prescaler is
    // 16 bits wide because PRESCALE may be as large as 65535; the per-bit
    // counters are 4 bits because STABLE_COUNT never exceeds 15.
    localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);
    localparam logic [3:0]  CNT_MAX = 4'(STABLE_COUNT - 1);

    // -------------------------------------------------------------------------
    // Two-flop synchroniser, always running regardless of ENABLE.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] sync_meta;
    logic [WIDTH-1:0] sync_s;

    // NOTE: every clocked block uses non-blocking assignments so all flops
    // sample the pre-edge values; blocking here would collapse the two stages.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync_meta <= '0;
            sync_s    <= '0;
        end else begin
            sync_meta <= PINS_IN;
            sync_s    <= sync_meta;
        end
    end

    // -------------------------------------------------------------------------
    // Sample-tick prescaler. Held at 0 while bypassed so that re-enabling
    // always produces the first tick exactly PRESCALE cycles later.
    // -------------------------------------------------------------------------
    logic [15:0] pre_cnt;
    logic        tick;

    assign tick = ENABLE && (pre_cnt == PRE_MAX);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pre_cnt <= '0;
        end else if (!ENABLE || tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 16'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Per-bit debounce. A counter tracks how many consecutive ticks have seen
    // the synchronised level differ from the accepted level; any tick that
    // agrees with the accepted level restarts it (glitch rejection).
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0][3:0] cnt_q;
    logic [WIDTH-1:0][3:0] cnt_next;
    logic [WIDTH-1:0]      level_next;

    // NOTE: outputs of this always_comb get a default before any branch so
    // no path leaves them unassigned, which would otherwise infer latches.
    always_comb begin
        level_next = GPIOIN;
        cnt_next   = cnt_q;
        if (!ENABLE) begin
            level_next = sync_s;
            cnt_next   = '0;
        end else if (tick) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_s[i] == GPIOIN[i]) begin
                    cnt_next[i] = 4'd0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    level_next[i] = sync_s[i];
                    cnt_next[i]   = 4'd0;
                end else begin
                    cnt_next[i] = cnt_q[i] + 4'd1;
                end
            end
        end
    end

    // NOTE: the counters are ordinary flops, not a RAM, so they are cleared
    // by reset along with everything else; partial counts never survive it.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Accepted level and edge pulses. The pulses are registered on the same
    // edge that updates GPIOIN, so they are high for exactly the cycle after
    // that edge. A bit cannot rise and fall at once, so RISE & FALL == 0.
    // -------------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            GPIOIN <= '0;
            RISE   <= '0;
            FALL   <= '0;
        end else begin
            GPIOIN <= level_next;
            RISE   <= level_next & ~GPIOIN;
            FALL   <= ~level_next & GPIOIN;
        end
    end

    // -------------------------------------------------------------------------
    // Sticky pending flags and interrupt. A new event outranks a clear in the
    // same cycle. IRQ is registered from the next pending value so that it
    // always equals the OR of IRQ_PENDING with no extra cycle of delay.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] pend_next;

    assign pend_next = (IRQ_PENDING & ~IRQ_CLEAR) | RISE | FALL;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            IRQ_PENDING <= '0;
            IRQ         <= 1'b0;
        end else begin
            IRQ_PENDING <= pend_next;
            IRQ         <= |pend_next;
        end
    end

endmodule

// File: tb/tb_gpio_in_debounce.sv
// -----------------------------------------------------------------------------
// Testbench for gpio_in_debounce (PRESCALE=4, STABLE_COUNT=3, WIDTH=16).
// A cycle-level behavioural model runs alongside the DUT and is compared on
// every falling clock edge; directed sequences add literal expectations, and
// a randomized phase exercises enable toggling, pin noise and clears.
// -----------------------------------------------------------------------------
module tb_gpio_in_debounce;

    localparam int W  = 16;
    localparam int PS = 4;
    localparam int SC = 3;

    logic         HCLK = 1'b0;
    logic         HRESETn;
    logic [W-1:0] PINS_IN;
    logic         ENABLE;
    logic [W-1:0] IRQ_CLEAR;
    logic [W-1:0] GPIOIN;
    logic [W-1:0] RISE;
    logic [W-1:0] FALL;
    logic [W-1:0] IRQ_PENDING;
    logic         IRQ;

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    gpio_in_debounce #(
        .WIDTH       (W),
        .PRESCALE    (PS),
        .STABLE_COUNT(SC)
    ) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .PINS_IN    (PINS_IN),
        .ENABLE     (ENABLE),
        .IRQ_CLEAR  (IRQ_CLEAR),
        .GPIOIN     (GPIOIN),
        .RISE       (RISE),
        .FALL       (FALL),
        .IRQ_PENDING(IRQ_PENDING),
        .IRQ        (IRQ)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model: the pin is seen two cycles late; ticks occur every
    // PS enabled cycles counted from enable/reset; a bit takes the new level
    // once SC consecutive ticks have all disagreed with the current level.
    // -------------------------------------------------------------------------
    logic [W-1:0] m_pin1, m_pin2, m_level, m_rise, m_fall, m_pend;
    logic         m_irq;
    int           m_phase;
    int           m_streak [W];

    task automatic model_reset();
        m_pin1 = '0; m_pin2 = '0; m_level = '0; m_rise = '0; m_fall = '0;
        m_pend = '0; m_irq = 1'b0; m_phase = 0;
        for (int i = 0; i < W; i++) m_streak[i] = 0;
    endtask

    task automatic model_clock();
        logic [W-1:0] seen, new_level;
        bit           is_tick;
        seen      = m_pin2;
        new_level = m_level;
        if (!ENABLE) begin
            new_level = seen;
            m_phase   = 0;
            for (int i = 0; i < W; i++) m_streak[i] = 0;
        end else begin
            is_tick = (m_phase == PS - 1);
            m_phase = is_tick ? 0 : m_phase + 1;
            if (is_tick) begin
                for (int i = 0; i < W; i++) begin
                    if (seen[i] != m_level[i]) begin
                        m_streak[i]++;
                        if (m_streak[i] == SC) begin
                            new_level[i] = seen[i];
                            m_streak[i]  = 0;
                        end
                    end else begin
                        m_streak[i] = 0;
                    end
                end
            end
        end
        m_pend  = (m_pend & ~IRQ_CLEAR) | m_rise | m_fall;
        m_irq   = |m_pend;
        m_rise  = new_level & ~m_level;
        m_fall  = m_level & ~new_level;
        m_level = new_level;
        m_pin2  = m_pin1;
        m_pin1  = PINS_IN;
    endtask

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) model_reset();
        else          model_clock();
    end

    // Compare process: all DUT outputs are registered, so the falling edge
    // is a stable sampling point.
    always @(negedge HCLK) begin
        if (run_cmp) begin
            check("gpioin",  32'(GPIOIN),      32'(m_level));
            check("rise",    32'(RISE),        32'(m_rise));
            check("fall",    32'(FALL),        32'(m_fall));
            check("pending", 32'(IRQ_PENDING), 32'(m_pend));
            check("irq",     32'(IRQ),         32'(m_irq));
            check("rise_and_fall_exclusive", 32'(RISE & FALL), 32'h0);
        end
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge HCLK);
    endtask

    initial begin
        int  n;
        bit  found;

        HRESETn   = 1'b0;
        ENABLE    = 1'b1;
        PINS_IN   = '0;
        IRQ_CLEAR = '0;
        run_cmp   = 1'b1;
        cycles(3);
        check("reset_gpioin",  32'(GPIOIN), 32'h0);
        check("reset_pending", 32'(IRQ_PENDING), 32'h0);
        check("reset_irq",     32'(IRQ), 32'h0);
        HRESETn = 1'b1;

        // Idle for 50 cycles: nothing may move.
        cycles(50);
        check("idle_gpioin", 32'(GPIOIN), 32'h0);
        check("idle_irq",    32'(IRQ), 32'h0);

        // Clean rise on bit 0: accepted 11..15 cycles after the change.
        PINS_IN[0] = 1'b1;
        found = 1'b0;
        n = 0;
        for (int i = 1; i <= 20 && !found; i++) begin
            @(negedge HCLK);
            n = i;
            if (GPIOIN[0]) found = 1'b1;
        end
        check("rise_seen", 32'(found), 32'h1);
        check("rise_latency_in_window", 32'(n >= 11 && n <= 15), 32'h1);
        check("rise_pulse", 32'(RISE), 32'h0001);
        @(negedge HCLK);
        check("rise_pulse_gone", 32'(RISE), 32'h0);
        check("rise_pending", 32'(IRQ_PENDING), 32'h0001);
        check("rise_irq", 32'(IRQ), 32'h1);

        // Glitch on bit 3: six cycles high covers at most two ticks.
        PINS_IN[3] = 1'b1;
        cycles(6);
        PINS_IN[3] = 1'b0;
        cycles(20);
        check("glitch_gpioin3", 32'(GPIOIN[3]), 32'h0);
        check("glitch_pending", 32'(IRQ_PENDING), 32'h0001);

        // Clear in the same cycle as FALL[0]: the set wins.
        PINS_IN[0] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge HCLK);
            if (FALL[0]) found = 1'b1;
        end
        check("fall_seen", 32'(found), 32'h1);
        IRQ_CLEAR = 16'h0001;
        @(negedge HCLK);
        IRQ_CLEAR = '0;
        check("set_beats_clear", 32'(IRQ_PENDING), 32'h0001);
        IRQ_CLEAR = 16'h0001;
        @(negedge HCLK);
        IRQ_CLEAR = '0;
        check("clear_pending", 32'(IRQ_PENDING), 32'h0);
        check("clear_irq", 32'(IRQ), 32'h0);

        // Bypass, multi-bit: GPIOIN follows exactly three cycles later.
        ENABLE = 1'b0;
        cycles(4);
        PINS_IN = 16'hA5A5;
        cycles(2);
        check("bypass_not_early", 32'(GPIOIN), 32'h0);
        @(negedge HCLK);
        check("bypass_gpioin", 32'(GPIOIN), 32'hA5A5);
        check("bypass_rise", 32'(RISE), 32'hA5A5);
        @(negedge HCLK);
        check("bypass_rise_gone", 32'(RISE), 32'h0);
        IRQ_CLEAR = '1;
        @(negedge HCLK);
        IRQ_CLEAR = '0;

        // Async reset mid-count, then a full three-tick qualification.
        PINS_IN = '0;
        cycles(5);
        IRQ_CLEAR = '1;
        @(negedge HCLK);
        IRQ_CLEAR = '0;
        cycles(2);
        ENABLE  = 1'b1;
        PINS_IN = '1;
        repeat (6) @(posedge HCLK);
        #2 HRESETn = 1'b0;
        #1;
        check("async_gpioin",  32'(GPIOIN), 32'h0);
        check("async_rise",    32'(RISE), 32'h0);
        check("async_fall",    32'(FALL), 32'h0);
        check("async_pending", 32'(IRQ_PENDING), 32'h0);
        check("async_irq",     32'(IRQ), 32'h0);
        @(negedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        found = 1'b0;
        n = 0;
        for (int i = 1; i <= 30 && !found; i++) begin
            @(negedge HCLK);
            n = i;
            if (GPIOIN == 16'hFFFF) found = 1'b1;
        end
        check("post_reset_latency", 32'(n), 32'd12);
        check("post_reset_rise", 32'(RISE), 32'hFFFF);

        // Randomized phase: sparse pin changes, enable toggles, clears.
        for (int c = 0; c < 4000; c++) begin
            @(negedge HCLK);
            if ($urandom_range(0, 249) == 0) ENABLE = ~ENABLE;
            if ($urandom_range(0, 5) == 0)
                PINS_IN = PINS_IN ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            IRQ_CLEAR = ($urandom_range(0, 7) == 0) ? 16'($urandom) : '0;
        end
        IRQ_CLEAR = '0;
        cycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_in_debounce.md
Name: gpio_in_debounce

Overview:
- Conditions the raw asynchronous input pins before they drive the GPIOIN input of the AHB GPIO peripheral.
- Per bit, it synchronises the pin to HCLK, debounces it against a shared sample tick, and produces one-cycle rise/fall pulses.
- Rise/fall events feed a sticky per-bit pending register that drives a single interrupt line to the processor subsystem.

Parameters:
- WIDTH, 16, number of pin bits.
- PRESCALE, 1000, HCLK cycles per sample tick; legal range 1..65535.
- STABLE_COUNT, 4, consecutive differing ticks needed to accept a new level; legal range 1..15.

Ports:
- HCLK  input  1  system clock.
- HRESETn  input  1  reset.
- PINS_IN  input  WIDTH  raw asynchronous pin levels.
- ENABLE  input  1  1 = debounce active; 0 = bypass (synchronised only).
- IRQ_CLEAR  input  WIDTH  single-cycle write-one-to-clear mask for pending bits.
- GPIOIN  output  WIDTH  debounced level; connects to the AHB GPIO GPIOIN port.
- RISE  output  WIDTH  one-cycle pulse per bit on an accepted 0->1 change.
- FALL  output  WIDTH  one-cycle pulse per bit on an accepted 1->0 change.
- IRQ_PENDING  output  WIDTH  sticky event flags.
- IRQ  output  1  OR-reduction of IRQ_PENDING.

Behaviour:
- Reset: HRESETn is asynchronous and active-low; the clock is HCLK.
  - While HRESETn is low, all state clears: sync flops, prescaler, per-bit counters, GPIOIN, RISE, FALL, IRQ_PENDING, IRQ all = 0.
  - If reset occurs mid-count, partial counts are discarded. After reset, a pin held at 1 is accepted as a normal rising change.
- Synchroniser: two flops per bit, always running. The signal "s" is the second-stage output.
- Prescaler:
  - Counts 0..PRESCALE-1 while ENABLE=1, then wraps to 0.
  - "tick" is asserted for the single cycle in which the count equals PRESCALE-1.
  - With PRESCALE=1, tick is asserted every cycle.
  - While ENABLE=0, the prescaler is held at 0.
- Per-bit debounce (ENABLE=1), evaluated only on tick:
  - If s == GPIOIN: counter <= 0.
  - Else if counter == STABLE_COUNT-1: GPIOIN bit <= s, counter <= 0, and the edge pulse fires.
  - Else: counter <= counter+1.
  - Consequence: a change is accepted on the STABLE_COUNT-th consecutive tick that sees it. Any tick showing the old level restarts the count (glitch rejection).
  - Counter width is 4 bits; it never exceeds STABLE_COUNT-1, so no wrap.
- Bypass (ENABLE=0):
  - GPIOIN <= s every cycle; counters are held at 0.
  - Edge pulses are still generated on every change.
- ENABLE transitions:
  - 1->0: takes effect next cycle; in-flight counts are dropped.
  - 0->1: the prescaler starts from 0, so the first tick comes PRESCALE cycles later.
- Edge pulses:
  - RISE/FALL are registered and asserted for exactly the one cycle after the HCLK edge that updates GPIOIN.
  - RISE and FALL are never both set for the same bit.
- Pending/IRQ:
  - IRQ_PENDING[i] <= (IRQ_PENDING[i] & ~IRQ_CLEAR[i]) | RISE[i] | FALL[i].
  - If set and clear occur in the same cycle, set wins.
  - IRQ is registered, i.e. equal to the OR of IRQ_PENDING with no extra latency beyond that register.
- Latency, pin change to GPIOIN:
  - Debounce mode: 2 cycles (sync) plus the time to the next tick, plus (STABLE_COUNT-1)*PRESCALE cycles, plus 1 cycle.
  - Bypass mode: 3 cycles.
- Simultaneous events: bits are fully independent. Multiple bits may toggle on the same tick, producing multi-bit RISE/FALL in the same cycle.

Test Plan:
- Reset/idle: PRESCALE=4, STABLE_COUNT=3, ENABLE=1, PINS_IN=0, release reset -> GPIOIN=0, RISE=FALL=0, IRQ=0 for 50 cycles.
- Clean rise: PINS_IN[0] 0->1 and held -> GPIOIN[0]=1 after ≤ 2+4+8+1 = 15 cycles; RISE[0] high exactly 1 cycle; IRQ_PENDING=0x0001; IRQ=1.
- Glitch rejection: PINS_IN[3] high for 6 cycles (covering fewer than 3 ticks), then low -> GPIOIN[3] stays 0; no RISE/FALL; IRQ_PENDING unchanged.
- Clear vs set: pending=0x0001; pulse IRQ_CLEAR=0x0001 in the same cycle as FALL[0] -> IRQ_PENDING stays 0x0001. Pulse IRQ_CLEAR=0x0001 again with no event -> 0x0000, IRQ=0.
- Bypass and multi-bit: ENABLE=0, PINS_IN 0x0000->0xA5A5 -> GPIOIN=0xA5A5 exactly 3 cycles later; RISE=0xA5A5 for 1 cycle.
- Async reset mid-count: PINS_IN=0xFFFF, assert HRESETn low between ticks 1 and 2 -> all outputs 0 immediately. After release, GPIOIN=0xFFFF after a full 3-tick qualification, with RISE=0xFFFF.
